// File: rtl/lmsm_sequencer_if.sv
// rtl/lmsm_sequencer_if.sv - decode-side request and memory-stage transfer bundle for lmsm_sequencer
interface lmsm_sequencer_if;
  logic [3:0] instr_dec;
  logic [7:0] imm_dec;
  logic       start_valid;
  logic       flush;
  logic [2:0] k_out;
  logic       k_valid;
  logic       is_store;
  logic [2:0] offset_out;
  logic       seq_freeze;
  logic       seq_done;
  logic       busy;

  modport master (
    output instr_dec, imm_dec, start_valid, flush,
    input  k_out, k_valid, is_store, offset_out, seq_freeze, seq_done, busy
  );

  modport slave (
    input  instr_dec, imm_dec, start_valid, flush,
    output k_out, k_valid, is_store, offset_out, seq_freeze, seq_done, busy
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - LM/SM (and LA/SA when LMSM_LASA_EN is defined) multi-register transfer sequencer
// Issues one register index per cycle, lowest first, while freezing fetch/decode.
module lmsm_sequencer (
  input  logic                   clk,
  input  logic                   reset_n,
  lmsm_sequencer_if.slave        bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] count_q, count_d;
  logic       store_q, store_d;
  logic       done_q, done_d;

  logic       op_ok;
  logic       accept;
  logic [7:0] accept_mask;
  logic [2:0] low_idx;
  logic       last;

  logic [2:0] k_out;
  logic       k_valid;
  logic       is_store;
  logic [2:0] offset_out;
  logic       seq_freeze;
  logic       seq_done;
  logic       busy;

  always_comb begin
    op_ok = 1'b0;
    case (bus.instr_dec)
      4'b1100, 4'b1101: op_ok = 1'b1;
`ifdef LMSM_LASA_EN
      4'b1110, 4'b1111: op_ok = 1'b1;
`endif
      default:          op_ok = 1'b0;
    endcase
  end

  // LA/SA transfer the whole register file regardless of the immediate.
  assign accept_mask = bus.instr_dec[1] ? 8'hFF : bus.imm_dec;
  assign accept      = reset_n && (state_q == IDLE) && bus.start_valid && op_ok && !bus.flush;

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) low_idx = 3'(i);
    end
  end

  assign last = ((mask_q & (mask_q - 8'd1)) == 8'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
      count_q <= 3'd0;
      store_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      store_q <= store_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    count_d    = count_q;
    store_d    = store_q;
    done_d     = 1'b0;
    k_out      = 3'd0;
    k_valid    = 1'b0;
    is_store   = 1'b0;
    offset_out = 3'd0;
    seq_freeze = 1'b0;
    seq_done   = 1'b0;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        seq_done = done_q;
        if (accept) begin
          mask_d  = accept_mask;
          store_d = bus.instr_dec[0];
          count_d = 3'd0;
          if (accept_mask != 8'd0) begin
            state_d    = RUN;
            seq_freeze = 1'b1;
          end else begin
            // Empty list: report completion next cycle without stalling.
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        k_valid    = 1'b1;
        k_out      = low_idx;
        offset_out = count_q;
        is_store   = store_q;
        busy       = 1'b1;
        seq_freeze = !last;
        seq_done   = last;
        mask_d     = mask_q & ~(8'd1 << low_idx);
        count_d    = count_q + 3'd1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
      mask_d  = 8'd0;
      count_d = 3'd0;
      done_d  = 1'b0;
    end
  end

  assign bus.k_out      = k_out;
  assign bus.k_valid    = k_valid;
  assign bus.is_store   = is_store;
  assign bus.offset_out = offset_out;
  assign bus.seq_freeze = seq_freeze;
  assign bus.seq_done   = seq_done;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb/tb_lmsm_sequencer.sv - self-checking bench for lmsm_sequencer with a queue-based transfer model
module tb_lmsm_sequencer;

  logic clk;
  logic reset_n;
  lmsm_sequencer_if bus();

  lmsm_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] k;
    logic [2:0] off;
    logic       st;
  } xfer_t;

  xfer_t mq[$];
  logic  empty_done = 1'b0;

  int lk[$];
  int lo[$];
  int ls[$];
  int n_done, n_freeze, n_busy, last_done_k;

  logic       ex_kv, ex_done, ex_frz, ex_busy, ex_st, acc;
  logic [2:0] ex_k, ex_off, cnt;
  logic [7:0] m;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic op_enabled(input logic [3:0] op);
`ifdef LMSM_LASA_EN
    return op[3:2] == 2'b11;
`else
    return op == 4'b1100 || op == 4'b1101;
`endif
  endfunction

  task automatic clear_log();
    lk.delete(); lo.delete(); ls.delete();
    n_done = 0; n_freeze = 0; n_busy = 0; last_done_k = -1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [3:0] op, input logic [7:0] imm);
    bus.start_valid = sv;
    bus.instr_dec   = op;
    bus.imm_dec     = imm;
  endtask

  // Reference: an accepted instruction becomes a queue of pending transfers.
  always @(negedge clk) begin
    ex_kv = 0; ex_done = 0; ex_frz = 0; ex_busy = 0; ex_st = 0; ex_k = 0; ex_off = 0;
    if (!reset_n) begin
      mq.delete();
      empty_done = 1'b0;
    end else begin
      acc = (mq.size() == 0) && bus.start_valid && op_enabled(bus.instr_dec) && !bus.flush;
      m   = bus.instr_dec[1] ? 8'hFF : bus.imm_dec;
      if (mq.size() > 0) begin
        ex_kv   = 1;
        ex_k    = mq[0].k;
        ex_off  = mq[0].off;
        ex_st   = mq[0].st;
        ex_busy = 1;
        ex_done = (mq.size() == 1);
        ex_frz  = (mq.size() > 1);
      end else begin
        ex_done = empty_done;
        ex_frz  = acc && (m != 8'd0);
      end
      empty_done = 1'b0;
      if (bus.flush) begin
        mq.delete();
      end else if (mq.size() > 0) begin
        void'(mq.pop_front());
      end else if (acc) begin
        if (m == 8'd0) empty_done = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
          if (m[i]) begin
            mq.push_back('{k: 3'(i), off: cnt, st: bus.instr_dec[0]});
            cnt = cnt + 3'd1;
          end
        end
      end
    end
    check("k_valid",    {7'd0, bus.k_valid},    {7'd0, ex_kv});
    check("k_out",      {5'd0, bus.k_out},      {5'd0, ex_k});
    check("offset_out", {5'd0, bus.offset_out}, {5'd0, ex_off});
    check("is_store",   {7'd0, bus.is_store},   {7'd0, ex_st});
    check("seq_freeze", {7'd0, bus.seq_freeze}, {7'd0, ex_frz});
    check("seq_done",   {7'd0, bus.seq_done},   {7'd0, ex_done});
    check("busy",       {7'd0, bus.busy},       {7'd0, ex_busy});
    if (reset_n) begin
      if (bus.k_valid) begin
        lk.push_back(int'(bus.k_out));
        lo.push_back(int'(bus.offset_out));
        ls.push_back(int'(bus.is_store));
      end
      if (bus.seq_done) begin
        n_done++;
        if (bus.k_valid) last_done_k = int'(bus.k_out);
      end
      if (bus.seq_freeze) n_freeze++;
      if (bus.busy) n_busy++;
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_kv"},   {7'd0, bus.k_valid},    8'd0);
    check({name, "_k"},    {5'd0, bus.k_out},      8'd0);
    check({name, "_off"},  {5'd0, bus.offset_out}, 8'd0);
    check({name, "_st"},   {7'd0, bus.is_store},   8'd0);
    check({name, "_frz"},  {7'd0, bus.seq_freeze}, 8'd0);
    check({name, "_done"}, {7'd0, bus.seq_done},   8'd0);
    check({name, "_busy"}, {7'd0, bus.busy},       8'd0);
  endtask

  initial begin
    int exp_k[4];
    exp_k = '{0, 2, 5, 7};
    reset_n = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 4'd0, 8'd0);
    clear_log();
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc();

    // LM 1010_0101
    clear_log();
    drive(1'b1, 4'b1100, 8'hA5);
    #1 check("lm_freeze_accept", {7'd0, bus.seq_freeze}, 8'd1);
    cyc();
    drive(1'b1, 4'b1101, 8'hFF);
    cyc();
    cyc();
    drive(1'b0, 4'd0, 8'd0);
    repeat (4) cyc();
    check("lm_count", 8'(lk.size()), 8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < lk.size()) begin
        check("lm_k",   8'(lk[i]), 8'(exp_k[i]));
        check("lm_off", 8'(lo[i]), 8'(i));
        check("lm_st",  8'(ls[i]), 8'd0);
      end
    end
    check("lm_freeze_cycles", 8'(n_freeze), 8'd4);
    check("lm_done_count", 8'(n_done), 8'd1);
    check("lm_done_k", 8'(last_done_k), 8'd7);

    // SM with empty list
    clear_log();
    drive(1'b1, 4'b1101, 8'h00);
    #1 check("sm0_no_freeze", {7'd0, bus.seq_freeze}, 8'd0);
    cyc();
    check("sm0_done_next", {7'd0, bus.seq_done}, 8'd1);
    drive(1'b0, 4'd0, 8'd0);
    cyc();
    check("sm0_done_once", {7'd0, bus.seq_done}, 8'd0);
    repeat (2) cyc();
    check("sm0_count", 8'(lk.size()), 8'd0);
    check("sm0_freeze", 8'(n_freeze), 8'd0);
    check("sm0_busy", 8'(n_busy), 8'd0);

    // SA
    clear_log();
    drive(1'b1, 4'b1111, 8'h00);
    cyc();
    drive(1'b0, 4'd0, 8'd0);
    repeat (10) cyc();
`ifdef LMSM_LASA_EN
    check("sa_count", 8'(lk.size()), 8'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < lk.size()) begin
        check("sa_k",   8'(lk[i]), 8'(i));
        check("sa_off", 8'(lo[i]), 8'(i));
        check("sa_st",  8'(ls[i]), 8'd1);
      end
    end
    check("sa_done", 8'(n_done), 8'd1);
`else
    check("sa_count", 8'(lk.size()), 8'd0);
    check("sa_done", 8'(n_done), 8'd0);
`endif

    // LM FF flushed on the third transfer
    clear_log();
    drive(1'b1, 4'b1100, 8'hFF);
    cyc();
    drive(1'b0, 4'd0, 8'd0);
    cyc();
    cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    #1;
    check("flush_kv", {7'd0, bus.k_valid}, 8'd0);
    check("flush_busy", {7'd0, bus.busy}, 8'd0);
    repeat (3) cyc();
    check("flush_count", 8'(lk.size()), 8'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < lk.size()) check("flush_k", 8'(lk[i]), 8'(i));
    end
    check("flush_no_done", 8'(n_done), 8'd0);

    clear_log();
    drive(1'b1, 4'b1100, 8'h01);
    cyc();
    drive(1'b0, 4'd0, 8'd0);
    repeat (3) cyc();
    check("lm01_count", 8'(lk.size()), 8'd1);
    if (lk.size() > 0) check("lm01_k", 8'(lk[0]), 8'd0);
    check("lm01_done", 8'(n_done), 8'd1);

    // Asynchronous reset mid-sequence
    clear_log();
`ifdef LMSM_LASA_EN
    drive(1'b1, 4'b1110, 8'h00);
`else
    drive(1'b1, 4'b1100, 8'hFF);
`endif
    cyc();
    drive(1'b0, 4'd0, 8'd0);
    cyc();
    cyc();
    check("rst_mid_busy", {7'd0, bus.busy}, 8'd1);
    #1 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    cyc();
    cyc();
    reset_n = 1'b1;
    clear_log();
    repeat (5) cyc();
    check("rst_idle_count", 8'(lk.size()), 8'd0);
    check("rst_idle_busy", 8'(n_busy), 8'd0);

    // Non-sequenced opcode, bubble, and flush beating accept
    clear_log();
    drive(1'b1, 4'b0100, 8'hFF);
    cyc();
    drive(1'b0, 4'b1100, 8'hFF);
    cyc();
    drive(1'b1, 4'b1100, 8'hFF);
    bus.flush = 1'b1;
    #1 check("flush_accept_frz", {7'd0, bus.seq_freeze}, 8'd0);
    cyc();
    bus.flush = 1'b0;
    drive(1'b0, 4'd0, 8'd0);
    check_all_zero("noseq");
    repeat (3) cyc();
    check("noseq_count", 8'(lk.size()), 8'd0);
    check("noseq_busy", 8'(n_busy), 8'd0);
    check("noseq_done", 8'(n_done), 8'd0);
    check("noseq_freeze", 8'(n_freeze), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  pipeline clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 instr_dec  input  4  opcode in decode: 1100 LM, 1101 SM, 1110 LA, 1111 SA.
REQ-005 imm_dec  input  8  register list; bit i set selects Ri.
REQ-006 start_valid  input  1  decode slot holds a real instruction, not a bubble.
REQ-007 flush  input  1  pipeline flush from branch/jump resolution.
REQ-008 k_out  output  3  register index of the current transfer; drives the k field in the memory stage.
REQ-009 k_valid  output  1  k_out and offset_out are valid this cycle.
REQ-010 is_store  output  1  current sequence is SM or SA.
REQ-011 offset_out  output  3  word offset from base: number of transfers already issued.
REQ-012 seq_freeze  output  1  hold fetch/decode pipeline registers.
REQ-013 seq_done  output  1  one-cycle pulse on the final transfer, or on acceptance of an empty list.
REQ-014 busy  output  1  high in RUN state.

Function
REQ-015 FSM states SHALL be IDLE and RUN.
REQ-016 Accept: in IDLE with start_valid=1, instr_dec in the enabled opcode set and flush=0. On acceptance, latch the mask (imm_dec for LM/SM, 8'hFF for LA/SA), latch is_store, clear count to 0.
REQ-017 Accept with mask nonzero: go to RUN; seq_freeze=1 combinationally in the acceptance cycle.
REQ-018 Accept with mask zero: stay in IDLE, seq_done=1 for the next cycle, no k_valid, no seq_freeze.
REQ-019 RUN, each cycle: k_out=index of the lowest set bit of the remaining mask, k_valid=1, offset_out=count; that bit clears and count increments at the clock edge.
REQ-020 First k_valid SHALL occur the cycle after acceptance; the number of k_valid cycles SHALL equal popcount(mask); indices issue in ascending order.
REQ-021 seq_freeze SHALL stay high in RUN while more than one bit remains, and SHALL be low in the final-transfer cycle so that decode advances.
REQ-022 Final transfer cycle: seq_done=1, k_valid=1; next state IDLE.
REQ-023 start_valid and instr_dec SHALL be ignored while in RUN.
REQ-024 flush=1 in any state SHALL force IDLE at the next edge, clear mask and count, and give k_valid=0, seq_freeze=0 and no seq_done from the next cycle. flush has priority over accept.
REQ-025 Non-LM/SM/LA/SA opcodes SHALL never start a sequence.
REQ-026 Outputs k_out, offset_out and is_store SHALL be 0 whenever k_valid=0.

Reset
REQ-027 When reset_n=0, regardless of clk: state=IDLE, mask=0, count=0, is_store=0; all outputs 0.
REQ-028 Reset mid-sequence SHALL abandon the sequence; after release, the block waits for a new accept.

Configuration
REQ-029 Macro LMSM_LASA_EN:
- Defined: 1110/1111 are accepted as all-register sequences (8 transfers, R0..R7).
- Undefined: 1110/1111 are treated as non-sequenced opcodes and never accepted; LM/SM are unaffected.

Verification
REQ-030 Reset, then LM with imm_dec=8'b1010_0101 and start_valid=1 -> k_out 0,2,5,7 on 4 consecutive cycles starting 1 cycle after accept; offset_out 0,1,2,3; seq_freeze high through k=5; seq_done with k=7; is_store=0.
REQ-031 SM with imm_dec=8'h00 -> no k_valid, seq_freeze never high, seq_done pulse 1 cycle after accept, state remains IDLE.
REQ-032 SA with LMSM_LASA_EN defined -> k_out 0..7 and offset 0..7 over 8 cycles with is_store=1. With the macro undefined -> k_valid never asserts.
REQ-033 LM with imm_dec=8'hFF, flush=1 on the third transfer cycle -> k_valid=0 the next cycle, busy=0, no seq_done; a subsequent LM with imm_dec=8'h01 -> a single transfer k=0.
REQ-034 reset_n dropped asynchronously mid-LA -> all outputs 0 immediately without a clock edge; after release, idle until a new accept.
REQ-035 start_valid=1 with opcode 0100, and start_valid=0 with opcode 1100 -> no sequence, all outputs 0.
